// File: rtl/universal_register_n.sv
// W-bit general-purpose register: hold, parallel load, shift, rotate and up/down
// count, with a registered terminal-count pulse and combinational status outputs.
module universal_register_n #(
    parameter int            W       = 8,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         CE,
    input  logic [2:0]   MODE,
    input  logic [W-1:0] D,
    input  logic         SI,
    output logic [W-1:0] Q,
    output logic [W-1:0] Q_n,
    output logic         SO_L,
    output logic         SO_R,
    output logic         ZERO,
    output logic         TC
);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_UP    = 3'b110,
        MODE_DOWN  = 3'b111
    } mode_e;

    localparam logic [W-1:0] ALL_ONES = '1;
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] r_q;
    logic         r_tc;
    logic [W-1:0] w_next;
    logic         w_wrap;
    mode_e        w_mode;

    assign w_mode = mode_e'(MODE);

    always_comb begin
        w_next = r_q;
        w_wrap = 1'b0;
        case (w_mode)
            MODE_HOLD: w_next = r_q;
            MODE_LOAD: w_next = D;
            MODE_SHL:  w_next = {r_q[W-2:0], SI};
            MODE_SHR:  w_next = {SI, r_q[W-1:1]};
            MODE_ROL:  w_next = {r_q[W-2:0], r_q[W-1]};
            MODE_ROR:  w_next = {r_q[0], r_q[W-1:1]};
            MODE_UP: begin
                w_next = r_q + ONE;
                w_wrap = (r_q == ALL_ONES);
            end
            MODE_DOWN: begin
                w_next = r_q - ONE;
                w_wrap = (r_q == '0);
            end
            default: w_next = r_q;
        endcase
    end

    // Reset beats CE, CE beats MODE; TC is only ever high the cycle after a wrap.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_q  <= RST_VAL;
            r_tc <= 1'b0;
        end else if (!CE) begin
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_next;
            r_tc <= w_wrap;
        end
    end

    assign Q    = r_q;
    assign Q_n  = ~r_q;
    assign SO_L = r_q[W-1];
    assign SO_R = r_q[0];
    assign ZERO = (r_q == '0);
    assign TC   = r_tc;

endmodule

// File: tb/tb_universal_register_n.sv
// Four instances (W=4 reset A, W=4 reset 3, W=2, W=32) share one stimulus stream;
// a width-generic arithmetic model checks every edge, scenario tasks check directed values.
module tb_universal_register_n;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        CE = 1'b0;
    logic [2:0]  MODE = 3'b000;
    logic [31:0] D = 32'd0;
    logic        SI = 1'b0;

    logic [3:0]  q_a, qn_a;
    logic [3:0]  q_b, qn_b;
    logic [1:0]  q_c, qn_c;
    logic [31:0] q_d, qn_d;
    logic        sol_a, sor_a, zero_a, tc_a;
    logic        sol_b, sor_b, zero_b, tc_b;
    logic        sol_c, sor_c, zero_c, tc_c;
    logic        sol_d, sor_d, zero_d, tc_d;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    universal_register_n #(.W(4), .RST_VAL(4'hA)) dut_a (
        .CLK(CLK), .RST_n(RST_n), .CE(CE), .MODE(MODE), .D(D[3:0]), .SI(SI),
        .Q(q_a), .Q_n(qn_a), .SO_L(sol_a), .SO_R(sor_a), .ZERO(zero_a), .TC(tc_a));
    universal_register_n #(.W(4), .RST_VAL(4'h3)) dut_b (
        .CLK(CLK), .RST_n(RST_n), .CE(CE), .MODE(MODE), .D(D[3:0]), .SI(SI),
        .Q(q_b), .Q_n(qn_b), .SO_L(sol_b), .SO_R(sor_b), .ZERO(zero_b), .TC(tc_b));
    universal_register_n #(.W(2), .RST_VAL(2'b00)) dut_c (
        .CLK(CLK), .RST_n(RST_n), .CE(CE), .MODE(MODE), .D(D[1:0]), .SI(SI),
        .Q(q_c), .Q_n(qn_c), .SO_L(sol_c), .SO_R(sor_c), .ZERO(zero_c), .TC(tc_c));
    universal_register_n #(.W(32), .RST_VAL(32'd0)) dut_d (
        .CLK(CLK), .RST_n(RST_n), .CE(CE), .MODE(MODE), .D(D), .SI(SI),
        .Q(q_d), .Q_n(qn_d), .SO_L(sol_d), .SO_R(sor_d), .ZERO(zero_d), .TC(tc_d));

    // Outputs gathered zero-extended so the model loop can treat all instances alike.
    logic [31:0] act_q [4];
    logic [31:0] act_qn[4];
    logic        act_sol[4], act_sor[4], act_zero[4], act_tc[4];
    assign act_q[0] = {28'd0, q_a};  assign act_qn[0] = {28'd0, qn_a};
    assign act_q[1] = {28'd0, q_b};  assign act_qn[1] = {28'd0, qn_b};
    assign act_q[2] = {30'd0, q_c};  assign act_qn[2] = {30'd0, qn_c};
    assign act_q[3] = q_d;           assign act_qn[3] = qn_d;
    assign act_sol[0] = sol_a; assign act_sol[1] = sol_b; assign act_sol[2] = sol_c; assign act_sol[3] = sol_d;
    assign act_sor[0] = sor_a; assign act_sor[1] = sor_b; assign act_sor[2] = sor_c; assign act_sor[3] = sor_d;
    assign act_zero[0] = zero_a; assign act_zero[1] = zero_b; assign act_zero[2] = zero_c; assign act_zero[3] = zero_d;
    assign act_tc[0] = tc_a; assign act_tc[1] = tc_b; assign act_tc[2] = tc_c; assign act_tc[3] = tc_d;

    // Reference model: value arithmetic modulo 2^w on a 32-bit container.
    int          wv[4] = '{4, 4, 2, 32};
    logic [31:0] rv[4] = '{32'hA, 32'h3, 32'h0, 32'h0};
    logic [31:0] m_q [4];
    logic        m_tc[4];
    logic [31:0] exp_q[$];
    bit          seen_rst = 1'b0;

    function automatic logic [31:0] mask_of(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    always @(posedge CLK) begin
        if (!RST_n) seen_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] mk;
            logic [31:0] q;
            int          w;
            w  = wv[k];
            mk = mask_of(w);
            q  = m_q[k];
            if (!RST_n) begin
                m_q[k] = rv[k]; m_tc[k] = 1'b0;
            end else if (!CE) begin
                m_tc[k] = 1'b0;
            end else begin
                m_tc[k] = 1'b0;
                case (MODE)
                    3'd1: m_q[k] = D & mk;
                    3'd2: m_q[k] = ((q << 1) | 32'(SI)) & mk;
                    3'd3: m_q[k] = (q >> 1) | (32'(SI) << (w - 1));
                    3'd4: m_q[k] = ((q << 1) | (q >> (w - 1))) & mk;
                    3'd5: m_q[k] = (q >> 1) | ((q & 32'd1) << (w - 1));
                    3'd6: begin m_tc[k] = (q == mk);    m_q[k] = (q + 32'd1) & mk; end
                    3'd7: begin m_tc[k] = (q == 32'd0); m_q[k] = (q - 32'd1) & mk; end
                    default: m_q[k] = q;
                endcase
            end
            exp_q.push_back(m_q[k]);
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            logic [31:0] mk;
            e  = exp_q.pop_front();
            mk = mask_of(wv[k]);
            if (seen_rst) begin
                n_vec++;
                if (act_q[k] !== e) begin
                    n_err++; $display("FAIL model_q[%0d] t=%0t got %h want %h", k, $time, act_q[k], e);
                end
                n_vec++;
                if (act_qn[k] !== (~e & mk)) begin
                    n_err++; $display("FAIL model_qn[%0d] t=%0t got %h want %h", k, $time, act_qn[k], ~e & mk);
                end
                n_vec++;
                if (act_sol[k] !== e[wv[k]-1] || act_sor[k] !== e[0]) begin
                    n_err++; $display("FAIL model_so[%0d] t=%0t got L%b R%b want L%b R%b", k, $time,
                                      act_sol[k], act_sor[k], e[wv[k]-1], e[0]);
                end
                n_vec++;
                if (act_zero[k] !== (e == 32'd0) || act_tc[k] !== m_tc[k]) begin
                    n_err++; $display("FAIL model_flags[%0d] t=%0t got Z%b TC%b want Z%b TC%b", k, $time,
                                      act_zero[k], act_tc[k], e == 32'd0, m_tc[k]);
                end
            end
        end
    end

    // Driver: inputs change on the falling edge; returns 2 time units after the rising edge.
    task automatic drive(input logic rst_n, input logic ce, input logic [2:0] mode,
                         input logic [31:0] d, input logic si);
        @(negedge CLK);
        RST_n = rst_n; CE = ce; MODE = mode; D = d; SI = si;
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 3'd6, 32'd0, 1'b1);
        drive(1'b0, 1'b1, 3'd6, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 3'd1, 32'hF, 1'b0);
            n_vec++;
            if (q_a !== 4'hA || qn_a !== 4'h5 || zero_a !== 1'b0 || tc_a !== 1'b0) begin
                n_err++; $display("FAIL reset_hold[%0d] got q=%h qn=%h z=%b tc=%b want q=a qn=5 z=0 tc=0",
                                  i, q_a, qn_a, zero_a, tc_a);
            end
            n_vec++;
            if (q_c !== 2'd0 || zero_c !== 1'b1 || qn_c !== 2'b11) begin
                n_err++; $display("FAIL reset_zero_w2 got q=%h z=%b qn=%h want 0 1 3", q_c, zero_c, qn_c);
            end
        end
    endtask

    task automatic test_load_shift();
        drive(1'b1, 1'b1, 3'd1, 32'h9, 1'b0);
        n_vec++;
        if (q_a !== 4'b1001) begin n_err++; $display("FAIL load got %b want 1001", q_a); end
        drive(1'b1, 1'b1, 3'd2, 32'hF, 1'b1);
        n_vec++;
        if (q_a !== 4'b0011) begin n_err++; $display("FAIL shl1 got %b want 0011", q_a); end
        drive(1'b1, 1'b1, 3'd2, 32'hF, 1'b1);
        n_vec++;
        if (q_a !== 4'b0111 || sol_a !== 1'b0) begin
            n_err++; $display("FAIL shl2 got %b so_l=%b want 0111 0", q_a, sol_a);
        end
        drive(1'b1, 1'b1, 3'd3, 32'hF, 1'b0);
        n_vec++;
        if (q_a !== 4'b0011 || sor_a !== 1'b1) begin
            n_err++; $display("FAIL shr got %b so_r=%b want 0011 1", q_a, sor_a);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] want[5];
        want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
        drive(1'b1, 1'b1, 3'd1, 32'h8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, (i < 4) ? 3'd4 : 3'd5, 32'hF, 1'b1);
            n_vec++;
            if (q_a !== want[i]) begin n_err++; $display("FAIL rotate[%0d] got %b want %b", i, q_a, want[i]); end
        end
    endtask

    task automatic test_count_wrap();
        logic [3:0] want_q[5];
        logic       want_tc[5];
        want_q  = '{4'hF, 4'h0, 4'h1, 4'h0, 4'hF};
        want_tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        drive(1'b1, 1'b1, 3'd1, 32'hE, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, (i < 3) ? 3'd6 : 3'd7, 32'h0, 1'b0);
            n_vec++;
            if (q_a !== want_q[i] || tc_a !== want_tc[i] || zero_a !== (want_q[i] == 4'h0)) begin
                n_err++; $display("FAIL count_wrap[%0d] got q=%h tc=%b z=%b want q=%h tc=%b", i, q_a, tc_a,
                                  zero_a, want_q[i], want_tc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        drive(1'b1, 1'b1, 3'd1, 32'h5, 1'b0);
        drive(1'b1, 1'b1, 3'd6, 32'h0, 1'b0);
        // Glitch reset low strictly between rising edges.
        RST_n = 1'b0; #1; RST_n = 1'b1; #1;
        n_vec++;
        if (q_b !== 4'h6) begin n_err++; $display("FAIL glitch_now got %h want 6", q_b); end
        drive(1'b1, 1'b1, 3'd6, 32'h0, 1'b0);
        n_vec++;
        if (q_b !== 4'h7) begin n_err++; $display("FAIL glitch_next got %h want 7", q_b); end
        drive(1'b0, 1'b1, 3'd6, 32'h0, 1'b0);
        n_vec++;
        if (q_b !== 4'h3 || tc_b !== 1'b0 || q_a !== 4'hA) begin
            n_err++; $display("FAIL sync_reset got b=%h tc=%b a=%h want 3 0 a", q_b, tc_b, q_a);
        end
    endtask

    task automatic test_width_sweep();
        drive(1'b0, 1'b1, 3'd0, 32'h0, 1'b0);
        drive(1'b1, 1'b1, 3'd7, 32'h0, 1'b0);
        n_vec++;
        if (q_c !== 2'b11 || tc_c !== 1'b1 || q_d !== 32'hFFFF_FFFF || tc_d !== 1'b1) begin
            n_err++; $display("FAIL down_wrap got c=%h/%b d=%h/%b want 3/1 ffffffff/1", q_c, tc_c, q_d, tc_d);
        end
        drive(1'b1, 1'b1, 3'd0, 32'h0, 1'b0);
        n_vec++;
        if (tc_c !== 1'b0 || tc_d !== 1'b0 || qn_d !== 32'd0) begin
            n_err++; $display("FAIL tc_one_cycle got c=%b d=%b qn_d=%h want 0 0 0", tc_c, tc_d, qn_d);
        end
        // W=2: alternating up/down from 3 wraps every edge.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, (i % 2 == 0) ? 3'd6 : 3'd7, 32'h0, 1'b0);
            n_vec++;
            if (tc_c !== 1'b1 || q_c !== ((i % 2 == 0) ? 2'b00 : 2'b11)) begin
                n_err++; $display("FAIL w2_wrap[%0d] got q=%h tc=%b want tc=1", i, q_c, tc_c);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load_shift();
        test_rotate();
        test_count_wrap();
        test_reset_mid_count();
        test_width_sweep();
        test_random();
        @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
